// File: rtl/stopwatch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_ctrl_if
//  Description : Signal bundle between the stopwatch controller and its
//                surroundings (buttons, digit counter chain, display latch).
//                master : the controller (drives cnt_en/cnt_clr/disp_hold/state)
//                slave  : the surroundings (drive buttons and at_max)
//  Ports       : btn_ss, btn_lc  raw button levels, asynchronous to clk
//                at_max          digit chain at 59:59.99
//                cnt_en          1-cycle advance pulse to the LS digit
//                cnt_clr         1-cycle synchronous clear of all digits
//                disp_hold       high = display shows the lap snapshot
//                state           FSM code IDLE=00 RUN=01 PAUSE=10 LAP=11
//  Revision    : 1.0 - initial release
// ============================================================================
interface stopwatch_ctrl_if;
    logic       btn_ss;
    logic       btn_lc;
    logic       at_max;
    logic       cnt_en;
    logic       cnt_clr;
    logic       disp_hold;
    logic [1:0] state;

    modport master (
        input  btn_ss,
        input  btn_lc,
        input  at_max,
        output cnt_en,
        output cnt_clr,
        output disp_hold,
        output state
    );

    modport slave (
        output btn_ss,
        output btn_lc,
        output at_max,
        input  cnt_en,
        input  cnt_clr,
        input  disp_hold,
        input  state
    );
endinterface
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_ctrl
//  Description : Stopwatch control FSM. Synchronises and edge-detects the
//                start/stop and lap/clear buttons, divides clk down to the
//                count tick, and sequences IDLE/RUN/PAUSE/LAP.
//  Parameters  : CLK_DIV      clk cycles per count tick (2 .. 2^24-1)
//                SYNC_STAGES  synchroniser depth per button (2 .. 3)
//  Ports       : clk          system clock, rising edge
//                reset        asynchronous, active-high
//                bus          stopwatch_ctrl_if.master (see interface file)
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
    parameter int CLK_DIV     = 500000,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic        clk,
    input  wire logic        reset,
    stopwatch_ctrl_if.master bus
);

    if (CLK_DIV < 2 || CLK_DIV > 24'hFFFFFF) begin : g_bad_clk_div
        $error("stopwatch_ctrl: CLK_DIV out of range");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync_stages
        $error("stopwatch_ctrl: SYNC_STAGES out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_LAP   = 2'b11
    } state_t;

    localparam logic [23:0] c_PRESC_TERM = 24'(CLK_DIV - 1);

    // Bit 0 = start/stop, bit 1 = lap/clear.
    logic [1:0] w_btn;
    logic [1:0] w_ev;

    assign w_btn = {bus.btn_lc, bus.btn_ss};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn_sync
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   r_prev;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_sync <= '0;
                r_prev <= 1'b0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], w_btn[gi]};
                r_prev <= r_sync[SYNC_STAGES-1];
            end
        end

        // Because r_prev restarts at 0, a button held through reset produces
        // exactly one event once the synchroniser has filled.
        assign w_ev[gi] = r_sync[SYNC_STAGES-1] & ~r_prev;
    end

    state_t      r_state;
    logic [23:0] r_presc;
    logic        r_cnt_en;
    logic        r_cnt_clr;
    logic        r_disp_hold;

    logic w_ss_ev;
    logic w_lc_ev;
    logic w_running;
    logic w_tick;
    logic w_overflow;

    assign w_ss_ev    = w_ev[0];
    assign w_lc_ev    = w_ev[1];
    assign w_running  = (r_state == S_RUN) || (r_state == S_LAP);
    assign w_tick     = (r_presc == c_PRESC_TERM);
    assign w_overflow = w_running && w_tick && bus.at_max;

    // Event priority in every state: start/stop first, then the terminal-count
    // stop, then lap/clear. A lap/clear that loses is simply dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_presc     <= '0;
            r_cnt_en    <= 1'b0;
            r_cnt_clr   <= 1'b0;
            r_disp_hold <= 1'b0;
        end else begin
            // Suppressing the pulse at_max keeps the chain parked at 59:59.99.
            r_cnt_en  <= w_tick && w_running && !bus.at_max;
            r_cnt_clr <= 1'b0;

            if (w_running) begin
                r_presc <= w_tick ? 24'd0 : r_presc + 24'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_ss_ev) begin
                        r_state <= S_RUN;
                    end else if (w_lc_ev) begin
                        r_cnt_clr   <= 1'b1;
                        r_disp_hold <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_ss_ev || w_overflow) begin
                        r_state <= S_PAUSE;
                    end else if (w_lc_ev) begin
                        r_state     <= S_LAP;
                        r_disp_hold <= 1'b1;
                    end
                end
                S_LAP: begin
                    // Leaving to PAUSE keeps the lap snapshot on the display.
                    if (w_ss_ev || w_overflow) begin
                        r_state <= S_PAUSE;
                    end else if (w_lc_ev) begin
                        r_state     <= S_RUN;
                        r_disp_hold <= 1'b0;
                    end
                end
                S_PAUSE: begin
                    if (w_ss_ev) begin
                        if (!bus.at_max) begin
                            r_state <= S_RUN;
                        end
                    end else if (w_lc_ev) begin
                        r_state     <= S_IDLE;
                        r_presc     <= '0;
                        r_cnt_clr   <= 1'b1;
                        r_disp_hold <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cnt_en    = r_cnt_en;
    assign bus.cnt_clr   = r_cnt_clr;
    assign bus.disp_hold = r_disp_hold;
    assign bus.state     = r_state;

endmodule
`default_nettype wire

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 500000: clk cycles per count tick (10 ms at 50 MHz); legal range 2..2^24-1.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flip-flop depth on each button input; legal range 2..3.
REQ-003 Port clk, input, 1: system clock; all state updates on rising edge.
REQ-004 Port reset, input, 1: reset, asynchronous, active-high.
REQ-005 Port btn_ss, input, 1: start/stop button, raw level, asynchronous to clk.
REQ-006 Port btn_lc, input, 1: lap/clear button, raw level, asynchronous to clk.
REQ-007 Port at_max, input, 1: digit chain at terminal value (59:59.99), combinational from the counter chain.
REQ-008 Port cnt_en, output, 1: single-cycle advance pulse to the least-significant digit counter.
REQ-009 Port cnt_clr, output, 1: single-cycle synchronous clear pulse to all digit counters.
REQ-010 Port disp_hold, output, 1: display latch freeze; high = show lap snapshot.
REQ-011 Port state, output, 2: FSM state code (IDLE=00, RUN=01, PAUSE=10, LAP=11).

Function
REQ-012 Each button SHALL pass through SYNC_STAGES flip-flops, then a rising-edge detector; one press SHALL yield exactly one 1-cycle event (ss_ev, lc_ev).
REQ-013 Button debounce is out of scope; every synchronized rising edge SHALL be treated as a press.
REQ-014 Prescaler SHALL be a 24-bit counter running 0..CLK_DIV-1 and wrapping to 0; tick SHALL be high in the cycle the count equals CLK_DIV-1.
REQ-015 Prescaler SHALL count only in RUN or LAP, SHALL hold its value in PAUSE, and SHALL reset to 0 on entry to IDLE.
REQ-016 cnt_en SHALL equal tick AND (state is RUN or LAP) AND NOT at_max, registered with 1 cycle latency.
REQ-017 IDLE transitions: ss_ev -> RUN; lc_ev -> stays IDLE and pulses cnt_clr.
REQ-018 RUN transitions: ss_ev -> PAUSE; lc_ev -> LAP; at_max with tick -> PAUSE, and the cnt_en pulse for that tick SHALL be suppressed.
REQ-019 LAP transitions: lc_ev -> RUN (release lap); ss_ev -> PAUSE with disp_hold still high; at_max with tick -> PAUSE with disp_hold still high.
REQ-020 PAUSE transitions: ss_ev -> RUN if at_max is 0, else stay PAUSE; lc_ev -> IDLE, pulse cnt_clr, drop disp_hold.
REQ-021 When ss_ev and lc_ev occur in the same cycle, ss_ev SHALL win and lc_ev SHALL be discarded.
REQ-022 disp_hold SHALL rise on entry to LAP, fall on lc_ev in LAP or on entry to IDLE, and hold its value otherwise.
REQ-023 cnt_clr SHALL be registered, high for exactly 1 cycle, 1 cycle after the lc_ev that caused it.
REQ-024 cnt_en and cnt_clr SHALL never both be high in the same cycle.
REQ-025 The state output SHALL be the registered FSM state code, with no combinational path from any input.

Reset
REQ-026 While reset is high: state=IDLE(00), cnt_en=0, cnt_clr=0, disp_hold=0, prescaler=0, all synchronizer and edge-detector flops=0.
REQ-027 Reset asserted mid-operation SHALL abort immediately, without emitting a cnt_clr pulse; clearing the digit chain is the digit counters' own reset.
REQ-028 After reset deasserts, a button already held high SHALL register as one press once its synchronizer fills.

Verification
REQ-029 Scenario start: CLK_DIV=4, at_max=0, press btn_ss -> state=01; cnt_en pulses every 4 cycles; first pulse within 4+SYNC_STAGES+2 cycles of the press.
REQ-030 Scenario pause: RUN, press btn_ss at prescaler=2 -> state=10, no cnt_en; press btn_ss again -> next cnt_en exactly 2 cycles after RUN re-entry plus 1 cycle of output latency.
REQ-031 Scenario lap: RUN, press btn_lc -> state=11, disp_hold=1, cnt_en continues; press btn_lc -> state=01, disp_hold=0.
REQ-032 Scenario clear: PAUSE, press btn_lc -> state=00, one cnt_clr pulse 1 cycle after lc_ev, disp_hold=0.
REQ-033 Scenario overflow: RUN, at_max=1 at a tick -> no cnt_en, state=10; press btn_ss -> state stays 10.
REQ-034 Scenario simultaneous and reset: ss_ev and lc_ev in the same cycle in RUN -> state=10, disp_hold=0; reset pulse in LAP -> all outputs 0, state=00 with no clk edge required.
